// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, DBG_BURST)
//   owner_t     : which port drives the DM bus this cycle (none / CPU / debug)
//   WORD_BYTES  : byte lanes per DM word
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic {
        IDLE      = 1'b0,
        DBG_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

endpackage

// File: rtl/dm_arb_perf_cnt.sv
// -----------------------------------------------------------------------------
// dm_arb_perf_cnt
// Two free-running, wrapping 32-bit event counters for the DM arbiter.
// Only compiled when DM_ARB_PERF_EN is defined; otherwise the file is empty.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears both counters)
//   cpu_stall       count enable: CPU access held off this cycle
//   dbg_gnt         count enable: debug beat accepted this cycle
//   perf_cpu_stall  cycles with cpu_stall=1
//   perf_dbg_beats  cycles with dbg_gnt=1
// -----------------------------------------------------------------------------
`ifdef DM_ARB_PERF_EN
module dm_arb_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_stall,
    input  logic        dbg_gnt,
    output logic [31:0] perf_cpu_stall,
    output logic [31:0] perf_dbg_beats
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cpu_stall <= '0;
            perf_dbg_beats <= '0;
        end else begin
            if (cpu_stall) perf_cpu_stall <= perf_cpu_stall + 32'd1;
            if (dbg_gnt)   perf_dbg_beats <= perf_dbg_beats + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
// Shares the single-port, byte-lane data memory between the CPU load/store
// port and a debug/loader port. The CPU wins by default with no added latency;
// the debug port receives bounded bursts, and a starvation counter forces a
// debug grant after STARVE_MAX stalled debug cycles.
//
// Optional feature macro: DM_ARB_PERF_EN (adds perf_cpu_stall/perf_dbg_beats).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU access request (we=0 means read)
//   cpu_rdata                load data, straight from mem_rdata
//   cpu_stall                CPU access not served this cycle
//   dbg_req/last/we/addr/wdata  debug beat request; last ends the burst
//   dbg_gnt                  debug beat accepted this cycle
//   dbg_rdata, dbg_rvalid    registered debug read data, 1 cycle after grant
//   mem_cs/we/addr/wdata     DM access bus, driven by the granted port
//   mem_rdata                DM combinational read data
//   perf_cpu_stall, perf_dbg_beats  (DM_ARB_PERF_EN only) event counters
// -----------------------------------------------------------------------------
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW         = 14,
    parameter int BURST_MAX  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [WORD_BYTES-1:0] cpu_we,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_last,
    input  logic [WORD_BYTES-1:0] dbg_we,
    input  logic [AW-1:0]         dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic                  dbg_gnt,
    output logic [31:0]           dbg_rdata,
    output logic                  dbg_rvalid,
    output logic                  mem_cs,
    output logic [WORD_BYTES-1:0] mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_cpu_stall,
    output logic [31:0]           perf_dbg_beats
`endif
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] BEAT_LIMIT   = BW'(BURST_MAX);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    arb_state_t    state, state_d;
    logic [BW-1:0] beat_cnt, beat_d;
    logic [SW-1:0] starve_cnt, starve_d;
    owner_t        owner;
    logic          cpu_gnt;

    // Next-state, beat counting and bus ownership.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state;
        beat_d  = beat_cnt;
        owner   = OWN_NONE;

        unique case (state)
            IDLE: begin
                if (cpu_req && (starve_cnt < STARVE_LIMIT)) begin
                    owner = OWN_CPU;
                end else if (dbg_req) begin
                    owner = OWN_DBG;
                    // A single-beat grant never leaves IDLE.
                    if (!dbg_last && (BURST_MAX > 1)) begin
                        state_d = DBG_BURST;
                        beat_d  = BW'(1);
                    end
                end
            end
            DBG_BURST: begin
                if (dbg_req) begin
                    owner  = OWN_DBG;
                    beat_d = beat_cnt + 1'b1;
                    if (dbg_last || (beat_d == BEAT_LIMIT)) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end
                end else begin
                    // Burst abandoned: hand the bus back without a grant.
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase

        // Nobody touches DM during reset, so no write can commit.
        if (rst) owner = OWN_NONE;
    end

    assign cpu_gnt   = (owner == OWN_CPU);
    assign dbg_gnt   = (owner == OWN_DBG);
    assign mem_cs    = cpu_gnt | dbg_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;
    assign cpu_rdata = mem_rdata;

    // Starvation guard: counts stalled debug cycles, saturating, cleared by
    // any debug grant.
    always_comb begin
        starve_d = starve_cnt;
        if (dbg_gnt) begin
            starve_d = '0;
        end else if (dbg_req && (starve_cnt < STARVE_LIMIT)) begin
            starve_d = starve_cnt + 1'b1;
        end
    end

    // DM bus mux.
    always_comb begin
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (owner)
            OWN_CPU: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_DBG: begin
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            starve_cnt <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state      <= state_d;
            beat_cnt   <= beat_d;
            starve_cnt <= starve_d;
            dbg_rvalid <= dbg_gnt && (dbg_we == '0);
            if (dbg_gnt && (dbg_we == '0)) dbg_rdata <= mem_rdata;
        end
    end

`ifdef DM_ARB_PERF_EN
    dm_arb_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .cpu_stall      (cpu_stall),
        .dbg_gnt        (dbg_gnt),
        .perf_cpu_stall (perf_cpu_stall),
        .perf_dbg_beats (perf_dbg_beats)
    );
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
// Self-checking bench for dm_port_arbiter with a behavioural DM model.
// Inputs are driven on the falling edge and outputs sampled 1 ns later;
// debug read results are scoreboarded in a queue.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic          dbg_last;
    logic [3:0]    dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt;
    logic [31:0]   dbg_rdata;
    logic          dbg_rvalid;
    logic          mem_cs;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
`ifdef DM_ARB_PERF_EN
    logic [31:0]   perf_cpu_stall;
    logic [31:0]   perf_dbg_beats;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(AW), .BURST_MAX(8), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_last   (dbg_last),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DM_ARB_PERF_EN
        ,
        .perf_cpu_stall (perf_cpu_stall),
        .perf_dbg_beats (perf_dbg_beats)
`endif
    );

    // Behavioural DM: combinational read, byte writes on posedge.
    logic [31:0] dm [0:(1<<AW)-1];
    assign mem_rdata = dm[mem_addr];

    always @(posedge clk) begin
        if (mem_cs) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (mem_we[i]) dm[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    typedef struct {
        logic          cpu_req;
        logic [3:0]    cpu_we;
        logic [AW-1:0] cpu_addr;
        logic [31:0]   cpu_wdata;
        logic          dbg_req;
        logic          dbg_last;
        logic [3:0]    dbg_we;
        logic [AW-1:0] dbg_addr;
        logic [31:0]   dbg_wdata;
        logic          exp_stall;
        logic          exp_gnt;
        logic          exp_cs;
        logic [3:0]    exp_we;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_wdata;
        logic          chk_rdata;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Start of a cycle: registered outputs are settled, compare the read pipe.
    task automatic next_cycle();
        @(negedge clk);
        check("dbg_rvalid", 32'(dbg_rvalid), 32'(sb_q.size() > 0));
        if (sb_q.size() > 0) check("dbg_rdata", dbg_rdata, sb_q.pop_front());
    endtask

    task automatic drive(input logic c_req, input logic [3:0] c_we, input logic [AW-1:0] c_addr,
                         input logic [31:0] c_wdata, input logic d_req, input logic d_last,
                         input logic [3:0] d_we, input logic [AW-1:0] d_addr, input logic [31:0] d_wdata);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        dbg_req   = d_req;
        dbg_last  = d_last;
        dbg_we    = d_we;
        dbg_addr  = d_addr;
        dbg_wdata = d_wdata;
    endtask

    task automatic idle_cycle();
        next_cycle();
        drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
        #1;
    endtask

    task automatic cpu_load(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
        next_cycle();
        drive(1'b1, 4'h0, addr, '0, 1'b0, 1'b0, 4'h0, '0, '0);
        #1;
        check({name, "_stall"}, 32'(cpu_stall), 32'd0);
        check({name, "_rdata"}, cpu_rdata, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        next_cycle();
        drive(v.cpu_req, v.cpu_we, v.cpu_addr, v.cpu_wdata,
              v.dbg_req, v.dbg_last, v.dbg_we, v.dbg_addr, v.dbg_wdata);
        #1;
        check($sformatf("v%0d_stall", idx), 32'(cpu_stall), 32'(v.exp_stall));
        check($sformatf("v%0d_gnt", idx),   32'(dbg_gnt),   32'(v.exp_gnt));
        check($sformatf("v%0d_cs", idx),    32'(mem_cs),    32'(v.exp_cs));
        check($sformatf("v%0d_we", idx),    32'(mem_we),    32'(v.exp_we));
        if (v.exp_cs) begin
            check($sformatf("v%0d_addr", idx),  32'(mem_addr), 32'(v.exp_addr));
            check($sformatf("v%0d_wdata", idx), mem_wdata,     v.exp_wdata);
        end
        if (v.chk_rdata) check($sformatf("v%0d_rdata", idx), cpu_rdata, v.exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_g;

        for (int i = 0; i < (1 << AW); i++) dm[i] = '0;

        // cpu_req,we,addr,wdata | dbg_req,last,we,addr,wdata | stall,gnt,cs,we,addr,wdata | chk,rdata
        vecs[0]  = '{1'b1, 4'hF, 14'h2000, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'hF, 14'h2000, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'h0, 14'h2000, 32'h0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'h0, 14'h2000, 32'h0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b1, 4'hF, 14'h0010, 32'h11111111,
                     1'b0, 1'b1, 1'b1, 4'hF, 14'h0010, 32'h11111111, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 4'h0, 14'h0010, 32'h0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'h0, 14'h0010, 32'h0, 1'b1, 32'h11111111};
        vecs[5]  = '{1'b1, 4'h3, 14'h0010, 32'hAAAAAAAA, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'h3, 14'h0010, 32'hAAAAAAAA, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 4'h0, 14'h0010, 32'h0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'h0, 14'h0010, 32'h0, 1'b1, 32'h1111AAAA};
        vecs[7]  = '{1'b1, 4'hF, 14'h0020, 32'h12345678, 1'b1, 1'b1, 4'hF, 14'h0030, 32'h00000055,
                     1'b0, 1'b0, 1'b1, 4'hF, 14'h0020, 32'h12345678, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b1, 4'hF, 14'h0030, 32'h00000055,
                     1'b0, 1'b1, 1'b1, 4'hF, 14'h0030, 32'h00000055, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 4'h0, 14'h0030, 32'h0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'h0, 14'h0030, 32'h0, 1'b1, 32'h00000055};
        vecs[10] = '{1'b1, 4'h8, 14'h0020, 32'hFF000000, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'h8, 14'h0020, 32'hFF000000, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 4'h0, 14'h0020, 32'h0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 4'h0, 14'h0020, 32'h0, 1'b1, 32'hFF345678};

        // Reset held two cycles with both ports requesting.
        rst = 1'b1;
        drive(1'b1, 4'hF, 14'h0040, 32'hBAD0BAD0, 1'b1, 1'b0, 4'hF, 14'h0041, 32'hBAD1BAD1);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            #1;
            check("rst_mem_cs", 32'(mem_cs), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
            check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        end
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
        #1;
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_nowrite", dm[14'h0041], 32'h0);

        // Single-cycle table: CPU traffic, byte lanes, single debug beats.
        for (int i = 0; i < 12; i++) apply(vecs[i], i);

        // Four-beat debug write burst with the CPU idle.
        for (int b = 1; b <= 4; b++) begin
            next_cycle();
            drive(1'b0, 4'h0, '0, '0, 1'b1, (b == 4), 4'hF, AW'(14'h2000 + b), 32'hB0000000 + 32'(b));
            #1;
            check($sformatf("burst_b%0d_gnt", b), 32'(dbg_gnt), 32'd1);
            check($sformatf("burst_b%0d_addr", b), 32'(mem_addr), 32'(14'h2000 + b));
            if (b > 1) check($sformatf("burst_b%0d_state", b), 32'(dut.state), 32'(DBG_BURST));
        end
        cpu_load("burst_end", 14'h2001, 32'hB0000001);
        check("burst_end_state", 32'(dut.state), 32'(IDLE));
        check("burst_end_gnt", 32'(dbg_gnt), 32'd0);
        cpu_load("burst_rd4", 14'h2004, 32'hB0000004);

        // Contention: CPU always requesting, debug burst without dbg_last.
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            drive(1'b1, 4'h0, 14'h2001, '0, 1'b1, (c == 17), 4'hF, AW'(14'h0100 + c), 32'(c));
            #1;
            exp_g = ((c >= 5) && (c <= 12)) || (c == 17);
            check($sformatf("cont_c%0d_gnt", c),   32'(dbg_gnt),   32'(exp_g));
            check($sformatf("cont_c%0d_stall", c), 32'(cpu_stall), 32'(exp_g));
            check($sformatf("cont_c%0d_addr", c),  32'(mem_addr),  exp_g ? 32'(14'h0100 + c) : 32'h2001);
        end
        idle_cycle();
        cpu_load("cont_after", 14'h0105, 32'd5);

        // Debug read of the end marker, then a two-beat read burst.
        next_cycle();
        drive(1'b1, 4'hF, 14'h3FFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, '0, '0);
        #1;
        check("marker_store_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b1, 4'h0, 14'h3FFF, '0);
        sb_q.push_back(32'hFFFFFFFF);
        #1;
        check("dbg_rd_gnt", 32'(dbg_gnt), 32'd1);
        idle_cycle();
        idle_cycle();
        next_cycle();
        drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0, 4'h0, 14'h3FFF, '0);
        sb_q.push_back(32'hFFFFFFFF);
        #1;
        check("dbg_rd2_b1_gnt", 32'(dbg_gnt), 32'd1);
        next_cycle();
        drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b1, 4'h0, 14'h2000, '0);
        sb_q.push_back(32'hDEADBEEF);
        #1;
        check("dbg_rd2_b2_gnt", 32'(dbg_gnt), 32'd1);
        idle_cycle();
        idle_cycle();

        // Reset arriving on beat 2 of a four-beat write burst.
        next_cycle();
        drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0, 4'hF, 14'h2100, 32'hC0000001);
        #1;
        check("rstb_b1_gnt", 32'(dbg_gnt), 32'd1);
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 4'h0, '0, '0, 1'b1, 1'b0, 4'hF, 14'h2101, 32'hC0000002);
        #1;
        check("rstb_b2_gnt", 32'(dbg_gnt), 32'd0);
        check("rstb_b2_cs", 32'(mem_cs), 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
        #1;
        check("rstb_state", 32'(dut.state), 32'(IDLE));
`ifdef DM_ARB_PERF_EN
        check("rstb_perf_beats", perf_dbg_beats, 32'd0);
        check("rstb_perf_stall", perf_cpu_stall, 32'd0);
`endif
        cpu_load("rstb_b2_data", 14'h2101, 32'h0);
        cpu_load("rstb_b1_data", 14'h2100, 32'hC0000001);
        idle_cycle();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
